pwm_dt_multi: RTL



---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_dt_multi_deadband.sv | 58 +++++
 rtl/pwm_dt_multi.sv | 62 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel dead-time PWM generator.
package pwm_pkg;

    localparam int PWM_WIDTH   = 11;
    localparam int PWM_DEAD    = 4;
    localparam int PWM_BUS_MAX = 1024;

    // Dead-time counter must hold 0..DEAD, with one value of headroom.
    function automatic int dt_cnt_w(input int dead);
        return $clog2(dead + 2);
    endfunction

    localparam int PWM_DT_CW = dt_cnt_w(PWM_DEAD);
    typedef logic [PWM_DT_CW-1:0] pwm_dt_cnt_t;

    function automatic logic [31:0] duty_lane(
        input logic [PWM_BUS_MAX-1:0] bus,
        input int unsigned            i,
        input int unsigned            w
    );
        return 32'((bus >> (i * w)) & {{(PWM_BUS_MAX-32){1'b0}}, (32'd1 << w) - 32'd1});
    endfunction

endpackage

// File: rtl/pwm_dt_multi_deadband.sv
// One channel of dead-time insertion: an output asserts only after DEAD+1
// consecutive enabled cycles of the matching raw level.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DEAD = PWM_DEAD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic PWM_sig,
    output logic PWM_sig_n
);

    localparam int            CW  = dt_cnt_w(DEAD);
    localparam logic [CW-1:0] SAT = CW'(DEAD);

    logic          raw_q;
    logic          en_q;
    logic [CW-1:0] run;
    logic [CW-1:0] run_nxt;
    logic          settled;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= SAT) ? SAT : v + 1'b1;
    endfunction

    // run counts how long raw has held its level, minus one; a disabled
    // previous cycle means the history starts over.
    always_comb begin
        run_nxt = (en_q && (raw == raw_q)) ? sat_inc(run) : '0;
        settled = (run_nxt == SAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q     <= 1'b0;
            en_q      <= 1'b0;
            run       <= '0;
            PWM_sig   <= 1'b0;
            PWM_sig_n <= 1'b0;
        end else begin
            raw_q <= raw;
            en_q  <= en;
            if (!en) begin
                run       <= '0;
                PWM_sig   <= 1'b0;
                PWM_sig_n <= 1'b0;
            end else begin
                run       <= run_nxt;
                PWM_sig   <= raw && settled;
                PWM_sig_n <= !raw && settled;
            end
        end
    end

endmodule

// File: rtl/pwm_dt_multi.sv
// Multi-channel complementary PWM with a shared period counter and
// double-buffered duties that switch only at the period wrap.
module pwm_dt_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int NUM_CH = 2,
    parameter int DEAD   = PWM_DEAD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic                    duty_vld,
    output logic [NUM_CH-1:0]       PWM_sig,
    output logic [NUM_CH-1:0]       PWM_sig_n,
    output logic                    period_start
);

    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [WIDTH-1:0]        cnt;
    logic [NUM_CH*WIDTH-1:0] pending;
    logic [NUM_CH*WIDTH-1:0] active;
    logic [NUM_CH-1:0]       raw;

    // A strobe landing on the wrap cycle bypasses pending so it is not lost
    // for a whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            pending      <= '0;
            active       <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            period_start <= (cnt == '0);
            if (duty_vld) begin
                pending <= duty;
            end
            if (cnt == CNT_LAST) begin
                active <= duty_vld ? duty : pending;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign raw[ch] = (cnt < WIDTH'(duty_lane(PWM_BUS_MAX'(active), ch, WIDTH)));

        pwm_deadband #(
            .DEAD (DEAD)
        ) u_deadband (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .raw       (raw[ch]),
            .PWM_sig   (PWM_sig[ch]),
            .PWM_sig_n (PWM_sig_n[ch])
        );
    end

endmodule
